// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the stream_demux block.
// Holds the routing FSM state type and the legal range of channel counts.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 16;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register for a single demux channel.
// The slot reports itself free when empty or when its current beat drains
// this cycle, so a drain and a refill can happen on the same edge.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             free
);

  assign free = !out_valid || out_ready;

  // Load a new beat on write; otherwise drop valid once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (wr_en) begin
      out_valid <= 1'b1;
      out_data  <= wr_data;
      out_last  <= wr_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1:NCH packet-routing stream demultiplexer.
// The channel is chosen on the first beat of a packet and held until the
// last beat. Optional macro DEMUX_DROP_EN turns an out-of-range select into
// a discarded packet with an err pulse instead of an input stall.
module stream_demux
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic [SELW-1:0]      select,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  output logic [NCH-1:0]       out_last,
  input  logic [NCH-1:0]       out_ready,
  output logic                 busy,
  output logic                 err
);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("stream_demux: NCH out of supported range");
  end

  localparam logic [SELW:0] NCH_V = (SELW+1)'(NCH);

  state_t                 state;
  logic [SELW-1:0]        cur_sel;
  logic [SELW-1:0]        wr_sel;
  logic [NCH-1:0]         slot_free;
  logic [(2**SELW)-1:0]   free_pad;
  logic [NCH-1:0]         wr_en;
  logic                   in_range;
  logic                   accept;
  logic                   write_ok;

  assign in_range = ({1'b0, select} < NCH_V);
  assign wr_sel   = (state == IDLE) ? select : cur_sel;
  assign accept   = in_valid && in_ready;
  assign write_ok = accept && (((state == IDLE) && in_range) || (state == ROUTE));

  // Widen the free flags to every encodable select so indexing never leaves the vector.
  always_comb begin
    free_pad = '0;
    free_pad[NCH-1:0] = slot_free;
  end

  // Ready depends only on state, select and the target slot, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (in_range) begin
            in_ready = free_pad[select];
          end else begin
`ifdef DEMUX_DROP_EN
            in_ready = 1'b1;
`else
            in_ready = 1'b0;
`endif
          end
        end
        ROUTE: in_ready = free_pad[cur_sel];
`ifdef DEMUX_DROP_EN
        DROP: in_ready = 1'b1;
`endif
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Decode the single slot that receives an accepted routed beat.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_en[i] = write_ok && (wr_sel == SELW'(i));
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en[i]),
      .wr_data   (in_data),
      .wr_last   (in_last),
      .out_ready (out_ready[i]),
      .out_data  (out_data[i*WIDTH +: WIDTH]),
      .out_valid (out_valid[i]),
      .out_last  (out_last[i]),
      .free      (slot_free[i])
    );
  end

  // Packet FSM: latch the channel on a first beat and track packet boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_sel <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              cur_sel <= select;
              if (!in_last) begin
                state <= ROUTE;
                busy  <= 1'b1;
              end
            end
`ifdef DEMUX_DROP_EN
            else begin
              err <= 1'b1;
              if (!in_last) begin
                state <= DROP;
                busy  <= 1'b1;
              end
            end
`endif
          end
        end
        ROUTE: begin
          if (accept && in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`ifdef DEMUX_DROP_EN
        DROP: begin
          if (accept && in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
